// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and FSM state type (used by tx and rx).
//               Optional parity build controlled by UART_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 16;
    localparam int BIT_IDX_W            = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
`ifdef UART_TX_PARITY_EN
        ,
        PARITY = 3'd3
`endif
    } uart_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_if.sv
// ============================================================================
// Module      : uart_tx_if
// Description : Byte handshake between a producer and the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_if;
    import uart_pkg::*;

    logic                 valid_in;
    logic [DATA_BITS-1:0] data_in;
    logic                 ready_out;
    logic                 busy_out;

    modport master (output valid_in, data_in, input ready_out, busy_out);
    modport slave  (input valid_in, data_in, output ready_out, busy_out);

endinterface

`default_nettype wire

// File: rtl/uart_baud_cnt.sv
// ============================================================================
// Module      : uart_baud_cnt
// Description : Bit-period counter with synchronous clear; end_bit marks the
//               last clock of each bit period.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  wire logic clk,
    input  wire logic n_rst,
    input  wire logic clr,
    output logic      end_bit
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last  = (r_cnt == c_last);
    assign end_bit = w_last & ~clr;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt <= '0;
        end else if (clr || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter, 8N1 by default; 8E1 when UART_TX_PARITY_EN
//               is defined. All outputs come straight from flops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  wire logic clk,
    input  wire logic n_rst,
    uart_tx_if.slave  bus,
    output logic      tx
);

    localparam logic [BIT_IDX_W-1:0] c_last_bit = BIT_IDX_W'(DATA_BITS - 1);

    uart_state_t          r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [BIT_IDX_W-1:0] r_bit_idx;
    logic                 r_tx;
    logic                 r_ready;
    logic                 r_busy;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    logic w_accept;
    logic w_end_bit;
    logic w_clr;

    assign w_accept = bus.valid_in & r_ready;
    // Holding the counter cleared in IDLE gives START a full first bit.
    assign w_clr    = (r_state == IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk     (clk),
        .n_rst   (n_rst),
        .clr     (w_clr),
        .end_bit (w_end_bit)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state  <= START;
                        r_shift  <= bus.data_in;
                        r_tx     <= 1'b0;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^bus.data_in;
`endif
                    end else begin
                        r_tx    <= 1'b1;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                START: begin
                    if (w_end_bit) begin
                        r_state <= DATA;
                        r_tx    <= r_shift[0];
                    end
                end
                DATA: begin
                    if (w_end_bit) begin
                        if (r_bit_idx == c_last_bit) begin
                            r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            r_state   <= PARITY;
                            r_tx      <= r_parity;
`else
                            r_state   <= STOP;
                            r_tx      <= 1'b1;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_end_bit) begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (w_end_bit) begin
                        r_state <= IDLE;
                        r_tx    <= 1'b1;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready_out = r_ready;
    assign bus.busy_out  = r_busy;
    assign tx            = r_tx;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx: frame model, handshake
//               timing, back-to-back, ignore-while-busy, reset, loopback.
//               Honours UART_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;
    import uart_pkg::*;

    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FB  = 11;
`else
    localparam int FB  = 10;
`endif

    typedef struct {
        logic [7:0] data;
        logic       par;
        bit         hold;
        int         pulse_at;
    } vec_t;

    logic clk = 1'b0;
    logic n_rst;
    logic tx;

    uart_tx_if bus ();

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         acc_cnt = 0;
    int         acc_times[$];
    logic [7:0] rx_q[$];

    always @(posedge clk) begin
        if (n_rst && bus.valid_in && bus.ready_out) begin
            acc_times.push_back(cyc);
            acc_cnt++;
        end
        cyc++;
    end

    // Independent mid-bit sampling receiver used for loopback checks.
    initial begin : rx_model
        logic [7:0] b;
        b = '0;
        forever begin
            @(negedge clk);
            if (n_rst === 1'b1 && tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB * (FB - 9)) @(negedge clk);
                if (tx === 1'b1) rx_q.push_back(b);
            end
        end
    end

    function automatic logic [FB-1:0] make_frame(input logic [7:0] d, input logic p);
        logic [10:0] f11;
        f11 = {1'b1, p, d, 1'b0};
`ifdef UART_TX_PARITY_EN
        return f11;
`else
        return {f11[10], f11[8:0]};
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input bit hold,
                              input int pulse_at, input string nm);
        logic [FB-1:0] exp;
        logic          seen;
        bit            bit_ok;
        int            waitc;
        int            hs_cnt;
        int            idx;
        waitc = 0;
        while (bus.ready_out !== 1'b1 && waitc < 400) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 400) chk({nm, "_ready_timeout"}, 32'(bus.ready_out), 32'd1);
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        @(posedge clk);
        #1;
        if (!hold) bus.valid_in = 1'b0;
        exp    = make_frame(d, par);
        hs_cnt = 0;
        for (int b = 0; b < FB; b++) begin
            bit_ok = 1'b1;
            seen   = exp[b];
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                idx = b * CPB + c;
                if (pulse_at >= 0 && idx == pulse_at) begin
                    bus.valid_in = 1'b1;
                    bus.data_in  = 8'h3C;
                end else if (pulse_at >= 0 && idx == pulse_at + 1) begin
                    bus.valid_in = 1'b0;
                end
                if (bit_ok && tx !== exp[b]) begin
                    bit_ok = 1'b0;
                    seen   = tx;
                end
                if (bus.ready_out === 1'b0 && bus.busy_out === 1'b1) hs_cnt++;
            end
            chk($sformatf("%s_bit%0d", nm, b), 32'(seen), 32'(exp[b]));
        end
        chk({nm, "_busy_cycles"}, hs_cnt, FB * CPB);
        @(negedge clk);
        chk({nm, "_gap_ready"}, 32'(bus.ready_out), 32'd1);
        chk({nm, "_gap_busy"}, 32'(bus.busy_out), 32'd0);
        chk({nm, "_gap_tx"}, 32'(tx), 32'd1);
    endtask

    vec_t       tbl[5];
    logic [7:0] rd;
    int         acc_before;
    int         stuck;

    initial begin
        tbl[0] = '{data: 8'h55, par: 1'b0, hold: 1'b0, pulse_at: -1};
        tbl[1] = '{data: 8'hA3, par: 1'b0, hold: 1'b1, pulse_at: -1};
        tbl[2] = '{data: 8'h07, par: 1'b1, hold: 1'b0, pulse_at: -1};
        tbl[3] = '{data: 8'h03, par: 1'b0, hold: 1'b0, pulse_at: -1};
        tbl[4] = '{data: 8'h81, par: 1'b0, hold: 1'b0, pulse_at: 40};

        n_rst        = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        #2 n_rst = 1'b0;
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_ready", 32'(bus.ready_out), 32'd0);
        chk("rst_busy", 32'(bus.busy_out), 32'd0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        #1 chk("rel_ready_before_edge", 32'(bus.ready_out), 32'd0);
        @(negedge clk);
        chk("rel_ready_first_edge", 32'(bus.ready_out), 32'd1);

        for (int i = 0; i < 5; i++) begin
            acc_before = acc_cnt;
            send_frame(tbl[i].data, tbl[i].par, tbl[i].hold, tbl[i].pulse_at,
                       $sformatf("tbl%0d_%02h", i, tbl[i].data));
            bus.valid_in = 1'b0;
            chk($sformatf("tbl%0d_accepts", i), acc_cnt - acc_before, 1);
        end

        // Back-to-back: valid held across the idle cycle.
        send_frame(8'h00, 1'b0, 1'b1, -1, "b2b_00");
        send_frame(8'hFF, 1'b0, 1'b0, -1, "b2b_ff");
        chk("b2b_spacing", acc_times[$] - acc_times[$-1], FB * CPB + 1);

        // Randomized bytes against the frame model.
        for (int i = 0; i < 8; i++) begin
            rd = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_frame(rd, 1'($countones(rd) % 2), 1'b0, -1, $sformatf("rnd%0d_%02h", i, rd));
        end

        // Loopback through the behavioural receiver.
        rx_q.delete();
        send_frame(8'h00, 1'b0, 1'b0, -1, "lb_00");
        send_frame(8'hFF, 1'b0, 1'b0, -1, "lb_ff");
        send_frame(8'h5A, 1'b0, 1'b0, -1, "lb_5a");
        chk("lb_count", rx_q.size(), 3);
        if (rx_q.size() == 3) begin
            chk("lb_byte0", 32'(rx_q[0]), 32'h00);
            chk("lb_byte1", 32'(rx_q[1]), 32'hFF);
            chk("lb_byte2", 32'(rx_q[2]), 32'h5A);
        end

        // Reset during data bit 4 of 0xC6 (bit 4 is 0).
        while (bus.ready_out !== 1'b1) @(negedge clk);
        bus.valid_in = 1'b1;
        bus.data_in  = 8'hC6;
        @(posedge clk);
        #1 bus.valid_in = 1'b0;
        repeat (86) @(negedge clk);
        chk("mid_rst_bit4_before", 32'(tx), 32'd0);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(tx), 32'd1);
        chk("mid_rst_busy", 32'(bus.busy_out), 32'd0);
        chk("mid_rst_ready", 32'(bus.ready_out), 32'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready_after", 32'(bus.ready_out), 32'd1);
        stuck = 0;
        for (int i = 0; i < FB * CPB + 10; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || bus.busy_out !== 1'b0) stuck++;
        end
        chk("mid_rst_not_resumed", stuck, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
